// File: rtl/attest_pkg.sv
// Shared definitions for the trace bitmap.
// Holds the bitmap geometry, the controller state encoding and helpers that
// split a hash index into its word address and bit position.
package attest_pkg;

    localparam int HASH_W    = 13;
    localparam int WORD_W    = 32;
    localparam int BM_DEPTH  = 256;
    localparam int ADDR_W    = $clog2(BM_DEPTH);
    localparam int BIT_W     = $clog2(WORD_W);
    // Wide enough to count every bit of the bitmap (8192 needs 14 bits).
    localparam int NEW_CNT_W = $clog2(BM_DEPTH * WORD_W) + 1;

    localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(BM_DEPTH - 1);

    typedef enum logic [1:0] {
        ST_CLEAR  = 2'd0,
        ST_RECORD = 2'd1,
        ST_DUMP   = 2'd2
    } state_e;

    function automatic logic [ADDR_W-1:0] hash_word(input logic [HASH_W-1:0] h);
        return h[HASH_W-1:BIT_W];
    endfunction

    function automatic logic [BIT_W-1:0] hash_bit(input logic [HASH_W-1:0] h);
        return h[BIT_W-1:0];
    endfunction

endpackage

// File: rtl/bitmap_ram.sv
// Bitmap storage: 256 x 32-bit, one write port and one synchronous read port.
// Ports:
//   clk          - clock
//   re / raddr   - read enable and address; rdata valid the following cycle
//   rdata        - registered read data (holds while re is low)
//   we / waddr   - write enable and address
//   wdata        - write data
// A read and write to the same address in one cycle returns the old word.
// Contents are not reset; the controller sweeps zeros after reset.
module bitmap_ram
    import attest_pkg::*;
(
    input  logic              clk,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WORD_W-1:0] rdata,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WORD_W-1:0] wdata
);

    logic [WORD_W-1:0] mem [BM_DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/trace_bitmap.sv
// Trace coverage bitmap: records 13-bit hash indices as set bits in an
// 8192-bit bitmap and streams the bitmap out on request.
// Ports:
//   clk, reset              - clock, asynchronous active-high reset
//   hash_valid, hash_value  - hash strobe and index (word=[12:5], bit=[4:0])
//   dump_start              - one-cycle request to stream the bitmap
//   rd_valid/rd_ready       - output handshake, rd_data = one bitmap word
//   rd_data, rd_last        - word data, high on word 255
//   busy                    - high while clearing or dumping
//   new_count               - distinct bits set since last clear
//   drop_count, overflow    - hashes discarded while busy (saturating), sticky flag
module trace_bitmap
    import attest_pkg::*;
#(
    parameter int CLEAR_ON_DUMP = 1,
    parameter int CNT_W         = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 hash_valid,
    input  logic [HASH_W-1:0]    hash_value,
    input  logic                 dump_start,
    output logic                 rd_valid,
    input  logic                 rd_ready,
    output logic [WORD_W-1:0]    rd_data,
    output logic                 rd_last,
    output logic                 busy,
    output logic [NEW_CNT_W-1:0] new_count,
    output logic [CNT_W-1:0]     drop_count,
    output logic                 overflow
);

    state_e                 state_q, state_d;
    logic [ADDR_W-1:0]      ptr_q, ptr_d;
    logic                   s1_valid_q, s1_valid_d;
    logic [ADDR_W-1:0]      s1_word_q, s1_word_d;
    logic [BIT_W-1:0]       s1_bit_q, s1_bit_d;
    logic                   wr_valid_q, wr_valid_d;
    logic [ADDR_W-1:0]      wr_word_q, wr_word_d;
    logic [WORD_W-1:0]      wr_data_q, wr_data_d;
    logic                   rd_pend_q, rd_pend_d;
    logic                   rd_valid_q, rd_valid_d;
    logic                   rd_last_q, rd_last_d;
    logic [WORD_W-1:0]      rd_data_q, rd_data_d;
    logic [NEW_CNT_W-1:0]   new_count_q, new_count_d;
    logic [CNT_W-1:0]       drop_count_q, drop_count_d;
    logic                   overflow_q, overflow_d;

    logic                   ram_re, ram_we;
    logic [ADDR_W-1:0]      ram_raddr, ram_waddr;
    logic [WORD_W-1:0]      ram_rdata, ram_wdata;
    logic [WORD_W-1:0]      old_word;
    logic                   rd_accept;

    bitmap_ram u_ram (
        .clk   (clk),
        .re    (ram_re),
        .raddr (ram_raddr),
        .rdata (ram_rdata),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata)
    );

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        s1_valid_d   = 1'b0;
        s1_word_d    = s1_word_q;
        s1_bit_d     = s1_bit_q;
        wr_valid_d   = 1'b0;
        wr_word_d    = wr_word_q;
        wr_data_d    = wr_data_q;
        rd_pend_d    = rd_pend_q;
        rd_valid_d   = rd_valid_q;
        rd_last_d    = rd_last_q;
        rd_data_d    = rd_data_q;
        new_count_d  = new_count_q;
        drop_count_d = drop_count_q;
        overflow_d   = overflow_q;
        ram_re       = 1'b0;
        ram_raddr    = ptr_q;
        ram_we       = 1'b0;
        ram_waddr    = ptr_q;
        ram_wdata    = '0;
        old_word     = ram_rdata;
        rd_accept    = rd_valid_q && rd_ready;

        // Stage 2 of the read-modify-write. It runs regardless of state so a
        // hash accepted in the dump_start cycle still lands before the dump.
        if (s1_valid_q) begin
            // The RAM read for this hash overlapped the previous write to the
            // same word and returned stale data; take the written value.
            if (wr_valid_q && (wr_word_q == s1_word_q)) begin
                old_word = wr_data_q;
            end
            ram_we     = 1'b1;
            ram_waddr  = s1_word_q;
            ram_wdata  = old_word | (WORD_W'(1) << s1_bit_q);
            wr_valid_d = 1'b1;
            wr_word_d  = s1_word_q;
            wr_data_d  = ram_wdata;
            if (!old_word[s1_bit_q]) begin
                new_count_d = new_count_q + 1'b1;
            end
        end

        if (hash_valid && (state_q != ST_RECORD)) begin
            if (drop_count_q != '1) begin
                drop_count_d = drop_count_q + 1'b1;
            end
            overflow_d = 1'b1;
        end

        case (state_q)
            ST_CLEAR: begin
                ram_we      = 1'b1;
                ram_waddr   = ptr_q;
                ram_wdata   = '0;
                new_count_d = '0;
                if (ptr_q == LAST_WORD) begin
                    state_d = ST_RECORD;
                    ptr_d   = '0;
                end else begin
                    ptr_d = ptr_q + 1'b1;
                end
            end

            ST_RECORD: begin
                if (hash_valid) begin
                    ram_re     = 1'b1;
                    ram_raddr  = hash_word(hash_value);
                    s1_valid_d = 1'b1;
                    s1_word_d  = hash_word(hash_value);
                    s1_bit_d   = hash_bit(hash_value);
                end
                if (dump_start) begin
                    state_d      = ST_DUMP;
                    ptr_d        = '0;
                    rd_pend_d    = 1'b0;
                    drop_count_d = '0;
                    overflow_d   = 1'b0;
                end
            end

            ST_DUMP: begin
                // Word read last cycle: capture into the stable output register.
                if (rd_pend_q) begin
                    rd_data_d  = ram_rdata;
                    rd_valid_d = 1'b1;
                    rd_last_d  = (ptr_q == LAST_WORD);
                    rd_pend_d  = 1'b0;
                end
                if (rd_accept) begin
                    rd_valid_d = 1'b0;
                    rd_last_d  = 1'b0;
                    if (CLEAR_ON_DUMP != 0) begin
                        ram_we    = 1'b1;
                        ram_waddr = ptr_q;
                        ram_wdata = '0;
                    end
                    if (ptr_q == LAST_WORD) begin
                        state_d = ST_RECORD;
                        ptr_d   = '0;
                        if (CLEAR_ON_DUMP != 0) begin
                            new_count_d = '0;
                        end
                    end else begin
                        ptr_d = ptr_q + 1'b1;
                    end
                end
                // Reads wait until the entry-cycle RMW write has committed,
                // and the next word is fetched as soon as the current one goes.
                if (!s1_valid_q && !rd_pend_q && (!rd_valid_q || rd_accept) &&
                    (state_d == ST_DUMP)) begin
                    ram_re    = 1'b1;
                    ram_raddr = ptr_d;
                    rd_pend_d = 1'b1;
                end
            end

            default: begin
                state_d = ST_CLEAR;
                ptr_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_CLEAR;
            ptr_q        <= '0;
            s1_valid_q   <= 1'b0;
            s1_word_q    <= '0;
            s1_bit_q     <= '0;
            wr_valid_q   <= 1'b0;
            wr_word_q    <= '0;
            wr_data_q    <= '0;
            rd_pend_q    <= 1'b0;
            rd_valid_q   <= 1'b0;
            rd_last_q    <= 1'b0;
            rd_data_q    <= '0;
            new_count_q  <= '0;
            drop_count_q <= '0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            s1_valid_q   <= s1_valid_d;
            s1_word_q    <= s1_word_d;
            s1_bit_q     <= s1_bit_d;
            wr_valid_q   <= wr_valid_d;
            wr_word_q    <= wr_word_d;
            wr_data_q    <= wr_data_d;
            rd_pend_q    <= rd_pend_d;
            rd_valid_q   <= rd_valid_d;
            rd_last_q    <= rd_last_d;
            rd_data_q    <= rd_data_d;
            new_count_q  <= new_count_d;
            drop_count_q <= drop_count_d;
            overflow_q   <= overflow_d;
        end
    end

    assign rd_valid   = rd_valid_q;
    assign rd_data    = rd_data_q;
    assign rd_last    = rd_last_q;
    assign busy       = (state_q != ST_RECORD);
    assign new_count  = new_count_q;
    assign drop_count = drop_count_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_trace_bitmap.sv
// Self-checking bench for trace_bitmap. Instance A uses the defaults;
// instance B shares every input but keeps its bitmap across dumps and has a
// 3-bit drop counter so saturation is reached.
module tb_trace_bitmap;

    logic        clk;
    logic        reset;
    logic        hash_valid;
    logic [12:0] hash_value;
    logic        dump_start;
    logic        rd_ready;

    logic        a_rd_valid, a_rd_last, a_busy, a_overflow;
    logic [31:0] a_rd_data;
    logic [13:0] a_new_count;
    logic [15:0] a_drop_count;

    logic        b_rd_valid, b_rd_last, b_busy, b_overflow;
    logic [31:0] b_rd_data;
    logic [13:0] b_new_count;
    logic [2:0]  b_drop_count;

    trace_bitmap #(.CLEAR_ON_DUMP(1), .CNT_W(16)) u_dut_a (
        .clk(clk), .reset(reset), .hash_valid(hash_valid), .hash_value(hash_value),
        .dump_start(dump_start), .rd_valid(a_rd_valid), .rd_ready(rd_ready),
        .rd_data(a_rd_data), .rd_last(a_rd_last), .busy(a_busy),
        .new_count(a_new_count), .drop_count(a_drop_count), .overflow(a_overflow)
    );

    trace_bitmap #(.CLEAR_ON_DUMP(0), .CNT_W(3)) u_dut_b (
        .clk(clk), .reset(reset), .hash_valid(hash_valid), .hash_value(hash_value),
        .dump_start(dump_start), .rd_valid(b_rd_valid), .rd_ready(rd_ready),
        .rd_data(b_rd_data), .rd_last(b_rd_last), .busy(b_busy),
        .new_count(b_new_count), .drop_count(b_drop_count), .overflow(b_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: plain bitmaps plus a count of hashes dropped since the
    // last dump request. new_count is the number of ones in the bitmap.
    logic [31:0] bm_a [256];
    logic [31:0] bm_b [256];
    logic [31:0] got_a [256];
    logic [31:0] got_b [256];
    int          drop_cnt;
    int          n_cmp;
    int          n_fail;
    int          dump_no;

    typedef struct {
        logic [12:0] h;
        logic [13:0] exp_cnt;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
        end
    endtask

    function automatic int popcnt_a();
        int s = 0;
        for (int i = 0; i < 256; i++) s += $countones(bm_a[i]);
        return s;
    endfunction

    function automatic int popcnt_b();
        int s = 0;
        for (int i = 0; i < 256; i++) s += $countones(bm_b[i]);
        return s;
    endfunction

    function automatic logic [31:0] b_drop_exp();
        return (drop_cnt > 7) ? 32'd7 : 32'(drop_cnt);
    endfunction

    task automatic model_set(input logic [12:0] h);
        int w;
        int b;
        w = int'(h) / 32;
        b = int'(h) % 32;
        bm_a[w] = bm_a[w] | (32'h1 << b);
        bm_b[w] = bm_b[w] | (32'h1 << b);
    endtask

    task automatic send_hash(input logic [12:0] h);
        hash_valid = 1'b1;
        hash_value = h;
        model_set(h);
        tick();
        hash_valid = 1'b0;
        tick();
        tick();
        tick();
    endtask

    // Reset, check reset state, then time the clear sweep. A hash is offered
    // at sweep cycle hash_at (if >= 0) and must be dropped.
    task automatic reset_and_clear(input int hash_at);
        int n;
        hash_valid = 1'b0;
        dump_start = 1'b0;
        rd_ready   = 1'b0;
        reset      = 1'b1;
        tick();
        tick();
        check("rst_a_rd_valid", 32'(a_rd_valid), 0);
        check("rst_a_rd_last", 32'(a_rd_last), 0);
        check("rst_a_rd_data", a_rd_data, 0);
        check("rst_a_new_count", 32'(a_new_count), 0);
        check("rst_a_drop_count", 32'(a_drop_count), 0);
        check("rst_a_overflow", 32'(a_overflow), 0);
        check("rst_a_busy", 32'(a_busy), 1);
        check("rst_b_rd_valid", 32'(b_rd_valid), 0);
        check("rst_b_busy", 32'(b_busy), 1);
        for (int i = 0; i < 256; i++) begin
            bm_a[i] = '0;
            bm_b[i] = '0;
        end
        drop_cnt = 0;
        reset = 1'b0;
        n = 0;
        while (a_busy && n < 400) begin
            if (n == hash_at) begin
                hash_valid = 1'b1;
                hash_value = 13'h0003;
                drop_cnt++;
            end
            tick();
            hash_valid = 1'b0;
            n++;
        end
        check("clear_busy_cycles", 32'(n), 256);
        check("clear_b_busy", 32'(b_busy), 0);
        check("clear_a_drop", 32'(a_drop_count), 32'(drop_cnt));
        check("clear_b_drop", 32'(b_drop_count), b_drop_exp());
        check("clear_a_overflow", 32'(a_overflow), (drop_cnt > 0) ? 1 : 0);
        check("clear_b_overflow", 32'(b_overflow), (drop_cnt > 0) ? 1 : 0);
        $display("reset+clear: busy for %0d cycles, drops %0d", n, drop_cnt);
    endtask

    // Stream the whole bitmap from both instances and compare to the model.
    task automatic run_dump(input bit rand_ready, input int stall_word, input int hash_pct,
                            input int abort_word, input int start_hash);
        int          a_idx;
        int          b_idx;
        int          cyc;
        int          stall_left;
        bit          prev_stalled;
        logic [31:0] prev_data;
        logic        prev_last;
        dump_no++;
        drop_cnt   = 0;
        dump_start = 1'b1;
        if (start_hash >= 0) begin
            hash_valid = 1'b1;
            hash_value = 13'(start_hash);
            model_set(13'(start_hash));
        end
        tick();
        dump_start   = 1'b0;
        hash_valid   = 1'b0;
        a_idx        = 0;
        b_idx        = 0;
        cyc          = 0;
        stall_left   = 5;
        prev_stalled = 1'b0;
        prev_data    = '0;
        prev_last    = 1'b0;
        while ((a_idx < 256 || b_idx < 256) && cyc < 4000) begin
            if (prev_stalled) begin
                check("stall_rd_valid", 32'(a_rd_valid), 1);
                check("stall_rd_data", a_rd_data, prev_data);
                check("stall_rd_last", 32'(a_rd_last), 32'(prev_last));
            end
            if (abort_word >= 0 && a_rd_valid && a_idx == abort_word) begin
                reset = 1'b1;
                #1;
                check("abort_a_rd_valid", 32'(a_rd_valid), 0);
                check("abort_b_rd_valid", 32'(b_rd_valid), 0);
                check("abort_a_busy", 32'(a_busy), 1);
                rd_ready = 1'b0;
                $display("dump %0d: reset asserted at word %0d", dump_no, a_idx);
                return;
            end
            rd_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (stall_word >= 0 && a_rd_valid && a_idx == stall_word && stall_left > 0) begin
                rd_ready = 1'b0;
                stall_left--;
                if (stall_left == 2) begin
                    hash_valid = 1'b1;
                    hash_value = 13'h0ABC;
                    drop_cnt++;
                end
            end
            if (!hash_valid && a_idx < 256 && $urandom_range(0, 99) < hash_pct) begin
                hash_valid = 1'b1;
                hash_value = 13'($urandom);
                drop_cnt++;
            end
            prev_stalled = a_rd_valid && !rd_ready;
            prev_data    = a_rd_data;
            prev_last    = a_rd_last;
            if (a_rd_valid && rd_ready && a_idx < 256) begin
                got_a[a_idx] = a_rd_data;
                check($sformatf("a_word%0d", a_idx), a_rd_data, bm_a[a_idx]);
                check($sformatf("a_last%0d", a_idx), 32'(a_rd_last), (a_idx == 255) ? 1 : 0);
                a_idx++;
            end
            if (b_rd_valid && rd_ready && b_idx < 256) begin
                got_b[b_idx] = b_rd_data;
                check($sformatf("b_word%0d", b_idx), b_rd_data, bm_b[b_idx]);
                check($sformatf("b_last%0d", b_idx), 32'(b_rd_last), (b_idx == 255) ? 1 : 0);
                b_idx++;
            end
            tick();
            hash_valid = 1'b0;
            cyc++;
        end
        rd_ready = 1'b0;
        if (cyc >= 4000) begin
            check("dump_timeout_beats", 32'(a_idx + b_idx), 512);
        end
        for (int i = 0; i < 256; i++) bm_a[i] = '0;
        tick();
        check("post_dump_a_busy", 32'(a_busy), 0);
        check("post_dump_b_busy", 32'(b_busy), 0);
        check("post_dump_a_new_count", 32'(a_new_count), 32'(popcnt_a()));
        check("post_dump_b_new_count", 32'(b_new_count), 32'(popcnt_b()));
        check("post_dump_a_drop", 32'(a_drop_count), 32'(drop_cnt));
        check("post_dump_b_drop", 32'(b_drop_count), b_drop_exp());
        check("post_dump_a_overflow", 32'(a_overflow), (drop_cnt > 0) ? 1 : 0);
        check("post_dump_b_overflow", 32'(b_overflow), (drop_cnt > 0) ? 1 : 0);
        $display("dump %0d: %0d/%0d words in %0d cycles, %0d drops", dump_no, a_idx, b_idx, cyc, drop_cnt);
    endtask

    initial begin
        vec_t vecs [3];
        n_cmp      = 0;
        n_fail     = 0;
        dump_no    = 0;
        drop_cnt   = 0;
        hash_valid = 1'b0;
        hash_value = '0;
        dump_start = 1'b0;
        rd_ready   = 1'b0;
        reset      = 1'b1;

        vecs[0] = '{h: 13'h0005, exp_cnt: 14'd1};
        vecs[1] = '{h: 13'h1FFF, exp_cnt: 14'd2};
        vecs[2] = '{h: 13'h0005, exp_cnt: 14'd2};

        // Reset, 256-cycle clear, hash dropped during it.
        reset_and_clear(10);

        // Table: single hashes with expected distinct-bit count.
        for (int i = 0; i < 3; i++) begin
            send_hash(vecs[i].h);
            check($sformatf("vec%0d_a_new_count", i), 32'(a_new_count), 32'(vecs[i].exp_cnt));
            check($sformatf("vec%0d_b_new_count", i), 32'(b_new_count), 32'(vecs[i].exp_cnt));
            $display("vector %0d: hash 0x%04h new_count %0d", i, vecs[i].h, a_new_count);
        end
        run_dump(1'b0, -1, 0, -1, -1);
        check("d1_word0", got_a[0], 32'h0000_0020);
        check("d1_word255", got_a[255], 32'h8000_0000);
        check("d1_new_count_after", 32'(a_new_count), 0);

        // Back-to-back hashes into one word exercise write forwarding.
        hash_valid = 1'b1;
        hash_value = 13'h0021; model_set(13'h0021); tick();
        hash_value = 13'h0022; model_set(13'h0022); tick();
        hash_value = 13'h0021; model_set(13'h0021); tick();
        hash_valid = 1'b0;
        tick(); tick(); tick();
        check("b2b_new_count", 32'(a_new_count), 2);
        $display("back-to-back 0x0021,0x0022,0x0021: new_count %0d", a_new_count);
        // Stall for 5 cycles at word 10 with a hash arriving meanwhile.
        run_dump(1'b0, 10, 0, -1, -1);
        check("b2b_word1", got_a[1], 32'h0000_0006);
        check("stall_drop_count", 32'(a_drop_count), 1);

        // Hash in the dump_start cycle; B keeps word 8 across two dumps.
        run_dump(1'b0, -1, 0, -1, 13'h0100);
        check("nc0_first_a_word8", got_a[8], 32'h0000_0001);
        check("nc0_first_b_word8", got_b[8], 32'h0000_0001);
        run_dump(1'b0, -1, 0, -1, -1);
        check("nc0_second_a_word8", got_a[8], 32'h0000_0000);
        check("nc0_second_b_word8", got_b[8], 32'h0000_0001);

        // Randomised bursts (narrow word range forces same-word collisions)
        // followed by dumps with random backpressure and dropped hashes.
        for (int r = 0; r < 3; r++) begin
            int sent = 0;
            for (int c = 0; c < 200; c++) begin
                hash_valid = ($urandom_range(0, 1) == 1);
                if ($urandom_range(0, 3) == 0)
                    hash_value = 13'($urandom);
                else
                    hash_value = {5'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 5'($urandom)};
                if (hash_valid) begin
                    model_set(hash_value);
                    sent++;
                end
                tick();
            end
            hash_valid = 1'b0;
            tick(); tick(); tick();
            check("rand_a_new_count", 32'(a_new_count), 32'(popcnt_a()));
            check("rand_b_new_count", 32'(b_new_count), 32'(popcnt_b()));
            $display("random burst %0d: %0d hashes, new_count %0d", r, sent, a_new_count);
            run_dump(1'b1, -1, 10, -1, -1);
        end

        // Reset in the middle of a dump, then a full clear and an empty dump.
        send_hash(13'h0C80);
        send_hash(13'h1234);
        run_dump(1'b0, -1, 0, 100, -1);
        reset_and_clear(-1);
        run_dump(1'b0, -1, 0, -1, -1);
        check("after_abort_a_word100", got_a[100], 0);
        check("after_abort_b_word145", got_b[145], 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/trace_bitmap.md
TRACE_BITMAP -- requirements
Module: trace_bitmap

Interface
REQ-001 SHALL have parameter CLEAR_ON_DUMP, default 1, meaning each bitmap word is zeroed once the consumer accepts it during a dump.
REQ-002 SHALL have parameter CNT_W, default 16, giving the width of drop_count.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 hash_valid  input  1  hash index strobe from the trace hasher; no backpressure, one index per cycle max.
REQ-006 hash_value  input  13  bitmap index: word = [12:5], bit = [4:0].
REQ-007 dump_start  input  1  single-cycle request to stream out the full bitmap.
REQ-008 rd_valid  output  1  rd_data holds a bitmap word.
REQ-009 rd_ready  input  1  consumer accepts rd_data when high with rd_valid.
REQ-010 rd_data  output  32  bitmap word, bit n = index {word,n}.
REQ-011 rd_last  output  1  high with rd_valid on word 255.
REQ-012 busy  output  1  high in CLEAR or DUMP.
REQ-013 new_count  output  14  distinct bits set since last clear.
REQ-014 drop_count  output  CNT_W  hashes discarded while busy; saturates at all-ones.
REQ-015 overflow  output  1  sticky: at least one hash dropped.

Function
REQ-016 SHALL hold 8192 bits as 256 x 32-bit words in a 1R1W synchronous-read RAM (read data one cycle after address).
REQ-017 SHALL implement FSM states CLEAR, RECORD, DUMP; CLEAR -> RECORD after word 255 written; RECORD -> DUMP on dump_start; DUMP -> RECORD after word 255 accepted if CLEAR_ON_DUMP=1, else -> RECORD likewise without zeroing.
REQ-018 In RECORD, accepted hash at cycle t SHALL issue a read at t and write (word | 1<<bit) at t+1 (two-stage read-modify-write).
REQ-019 SHALL forward the stage-2 write data to stage 1 when consecutive hashes hit the same word, so no set bit is lost.
REQ-020 SHALL increment new_count at t+2 only if the target bit was previously 0; duplicates leave it unchanged.
REQ-021 In CLEAR and DUMP, hash_valid SHALL be dropped: drop_count +1 (saturating), overflow set.
REQ-022 dump_start SHALL be ignored outside RECORD; on DUMP entry, overflow and drop_count SHALL clear and a RECORD write in flight SHALL complete first.
REQ-023 DUMP SHALL present words 0..255 in order; rd_data/rd_last SHALL stay stable while rd_valid=1 and rd_ready=0.
REQ-024 With CLEAR_ON_DUMP=1, each accepted word SHALL be written to zero and new_count SHALL be 0 on return to RECORD.
REQ-025 CLEAR SHALL write zero to words 0..255, one per cycle, 256 cycles.

Reset
REQ-026 Reset SHALL force state CLEAR with word pointer 0, rd_valid=0, rd_last=0, rd_data=0, new_count=0, drop_count=0, overflow=0, busy=1; pipeline valids 0.
REQ-027 RAM contents SHALL NOT be reset; the CLEAR sweep after reset release SHALL establish an all-zero bitmap.
REQ-028 Reset mid-dump or mid-RMW SHALL abandon the operation; rd_valid low from reset assertion.

Structure
REQ-029 Package attest_pkg SHALL hold HASH_W=13, WORD_W=32, BM_DEPTH=256, the state enum, and the word/bit index field slicing.
REQ-030 RAM SHALL be a separate sub-module bitmap_ram (1R1W, sync read, no reset).

Verification
REQ-031 Reset release -> busy=1 for 256 cycles; hash 0x0003 during it -> drop_count=1, overflow=1; then busy=0.
REQ-032 Hashes 0x0005, 0x1FFF, then dump with rd_ready=1 -> word0=0x00000020, word255=0x80000000, rd_last on 256th beat, new_count=2 before dump and 0 after.
REQ-033 Back-to-back hashes 0x0021, 0x0022, 0x0021 -> dumped word1=0x00000006, new_count=2.
REQ-034 rd_ready low for 5 cycles at word 10 -> rd_data/rd_last stable; a hash arriving then -> drop_count=1.
REQ-035 CLEAR_ON_DUMP=0: two successive dumps after hash 0x0100 -> word8=0x00000001 both times.
REQ-036 Reset asserted mid-dump at word 100 -> rd_valid=0 immediately; full 256-cycle CLEAR follows; next dump all zeros.
